// File: rtl/life_game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : life_game_pkg
//  Purpose  : Shared grid geometry, FSM/mode encodings, LFSR constants and
//             small helper functions for the Game of Life engine.
//  Contents : GRID_W/GRID_H/CELL_COUNT, index widths, state_e, mode_e,
//             LFSR seed and tap mask, cell_index(), lfsr_next(),
//             glider_pattern().
//  Revision : 1.0  initial release
// ============================================================================
package life_game_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_COUNT = GRID_W * GRID_H;

  localparam int IDX_W = $clog2(CELL_COUNT);  // 11 bits address 0..1199
  localparam int COL_W = $clog2(GRID_W);      // 6 bits for 0..39
  localparam int ROW_W = $clog2(GRID_H);      // 5 bits for 0..29

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELL_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic {
    LIFE = 1'b0,
    RAND = 1'b1
  } mode_e;

  // Right-shifting Fibonacci LFSR; taps 16,14,13,11 correspond to bits
  // 0,2,3,5 of the register in this orientation.
  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return IDX_W'(row) * IDX_W'(GRID_W) + IDX_W'(col);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAP_MASK), s[15:1]};
  endfunction

  // Power-on pattern: a glider heading towards +col/+row.
  function automatic logic [CELL_COUNT-1:0] glider_pattern();
    logic [CELL_COUNT-1:0] p;
    p = '0;
    p[cell_index(5'd0, 6'd1)] = 1'b1;
    p[cell_index(5'd1, 6'd2)] = 1'b1;
    p[cell_index(5'd2, 6'd0)] = 1'b1;
    p[cell_index(5'd2, 6'd1)] = 1'b1;
    p[cell_index(5'd2, 6'd2)] = 1'b1;
    return p;
  endfunction

endpackage : life_game_pkg
`default_nettype wire

// File: rtl/life_rule.sv
`default_nettype none
// ============================================================================
//  Module   : life_rule
//  Purpose  : Combinational Conway rule (B3/S23) for one cell.
//  Ports    : neighbours  in  8  live flags of the 8 surrounding cells
//             centre      in  1  current state of the cell
//             alive_next  out 1  state of the cell in the next generation
//  Revision : 1.0  initial release
// ============================================================================
module life_rule (
  input  logic [7:0] neighbours,
  input  logic       centre,
  output logic       alive_next
);

  logic [3:0] live_count;

  always_comb begin
    live_count = 4'd0;
    for (int k = 0; k < 8; k++) begin
      live_count = live_count + {3'd0, neighbours[k]};
    end
    alive_next = (live_count == 4'd3) || (centre && (live_count == 4'd2));
  end

endmodule : life_rule
`default_nettype wire

// File: rtl/life_game.sv
`default_nettype none
// ============================================================================
//  Module   : life_game
//  Purpose  : Game of Life engine on a toroidal 40x30 grid with an RGB332
//             pixel lookup for a 640x480 VGA raster.
//  Ports    : clock         in  1   system/pixel clock, rising edge
//             reset         in  1   synchronous active-high reset
//             button        in  4   [0] run/pause [1] step [2] randomize
//                                   [3] clear (levels, pre-debounced)
//             x_position    in  10  current pixel column
//             y_position    in  9   current pixel row
//             inside_video  in  1   visible-region flag
//             color         out 8   RGB332 colour, one clock after position
//  Revision : 1.0  initial release
// ============================================================================
module life_game
  import life_game_pkg::*;
#(
  parameter int unsigned CELL_SHIFT  = 4,
  parameter int unsigned STEP_PERIOD = 25000000,
  parameter logic [7:0]  ALIVE_COLOR = 8'h1C,
  parameter logic [7:0]  DEAD_COLOR  = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] button,
  input  logic [9:0] x_position,
  input  logic [8:0] y_position,
  input  logic       inside_video,
  output logic [7:0] color
);

  localparam int                  TIMER_W    = $clog2(STEP_PERIOD);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(STEP_PERIOD - 1);
  localparam logic [9:0]          X_LIMIT    = 10'(GRID_W << CELL_SHIFT);
  localparam logic [8:0]          Y_LIMIT    = 9'(GRID_H << CELL_SHIFT);
  localparam logic [CELL_COUNT-1:0] GLIDER_INIT = glider_pattern();

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                 state_q,    state_d;
  mode_e                  mode_q,     mode_d;
  logic [IDX_W-1:0]       idx_q,      idx_d;
  logic [COL_W-1:0]       col_q,      col_d;
  logic [ROW_W-1:0]       row_q,      row_d;
  logic [TIMER_W-1:0]     timer_q,    timer_d;
  logic                   running_q,  running_d;
  logic [CELL_COUNT-1:0]  cur_q,      cur_d;
  logic [CELL_COUNT-1:0]  nxt_q,      nxt_d;
  logic [15:0]            lfsr_q,     lfsr_d;
  logic [3:0]             btn_prev_q, btn_prev_d;
  logic [7:0]             color_q,    color_d;

  logic [3:0] btn_rise;
  assign btn_rise = button & ~btn_prev_q;

  // --------------------------------------------------------------------------
  // Neighbour fetch for the sweep cell, with toroidal wrap on both axes
  // --------------------------------------------------------------------------
  logic [COL_W-1:0] col_l, col_r;
  logic [ROW_W-1:0] row_u, row_dn;
  logic [7:0]       nbr_bits;
  logic             centre_bit;
  logic             rule_next;

  always_comb begin
    col_l  = (col_q == '0)       ? COL_LAST : col_q - 1'b1;
    col_r  = (col_q == COL_LAST) ? '0       : col_q + 1'b1;
    row_u  = (row_q == '0)       ? ROW_LAST : row_q - 1'b1;
    row_dn = (row_q == ROW_LAST) ? '0       : row_q + 1'b1;
    nbr_bits = {cur_q[cell_index(row_u,  col_l)],
                cur_q[cell_index(row_u,  col_q)],
                cur_q[cell_index(row_u,  col_r)],
                cur_q[cell_index(row_q,  col_l)],
                cur_q[cell_index(row_q,  col_r)],
                cur_q[cell_index(row_dn, col_l)],
                cur_q[cell_index(row_dn, col_q)],
                cur_q[cell_index(row_dn, col_r)]};
    centre_bit = cur_q[idx_q];
  end

  life_rule u_rule (
    .neighbours (nbr_bits),
    .centre     (centre_bit),
    .alive_next (rule_next)
  );

  // --------------------------------------------------------------------------
  // Display lookup: only the current buffer is read, so the picture changes
  // exclusively on the COMMIT edge.
  // --------------------------------------------------------------------------
  logic [COL_W-1:0] disp_col;
  logic [ROW_W-1:0] disp_row;
  logic             disp_valid;
  logic [IDX_W-1:0] disp_idx;

  always_comb begin
    disp_col   = x_position[CELL_SHIFT +: COL_W];
    disp_row   = y_position[CELL_SHIFT +: ROW_W];
    disp_valid = inside_video && (x_position < X_LIMIT) && (y_position < Y_LIMIT);
    // Off-grid positions are parked on index 0 so the select stays in range.
    disp_idx   = disp_valid ? cell_index(disp_row, disp_col) : '0;
    color_d    = (disp_valid && cur_q[disp_idx]) ? ALIVE_COLOR : DEAD_COLOR;
  end

  // --------------------------------------------------------------------------
  // Control: clear > randomize > step/timer; run toggle always applies
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    col_d      = col_q;
    row_d      = row_q;
    timer_d    = timer_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    running_d  = running_q ^ btn_rise[0];
    lfsr_d     = lfsr_next(lfsr_q);
    btn_prev_d = button;

    if (btn_rise[3]) begin
      // Clear aborts any sweep in progress and wipes both buffers.
      cur_d   = '0;
      nxt_d   = '0;
      state_d = IDLE;
      timer_d = '0;
      idx_d   = '0;
      col_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_rise[2]) begin
            state_d = SWEEP;
            mode_d  = RAND;
            timer_d = '0;
            idx_d   = '0;
            col_d   = '0;
            row_d   = '0;
          end else if (btn_rise[1] || (running_q && (timer_q == TIMER_LAST))) begin
            state_d = SWEEP;
            mode_d  = LIFE;
            timer_d = '0;
            idx_d   = '0;
            col_d   = '0;
            row_d   = '0;
          end else if (running_q) begin
            timer_d = timer_q + 1'b1;
          end else begin
            timer_d = '0;
          end
        end

        SWEEP: begin
          nxt_d[idx_q] = (mode_q == RAND) ? lfsr_q[0] : rule_next;
          if (idx_q == IDX_LAST) begin
            state_d = COMMIT;
            idx_d   = '0;
            col_d   = '0;
            row_d   = '0;
          end else begin
            // col/row track idx so neighbour addressing needs no divider.
            idx_d = idx_q + 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end

        COMMIT: begin
          cur_d   = nxt_q;
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= LIFE;
      idx_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      timer_q    <= '0;
      running_q  <= 1'b1;
      cur_q      <= GLIDER_INIT;
      nxt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      btn_prev_q <= '0;
      color_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      timer_q    <= timer_d;
      running_q  <= running_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      lfsr_q     <= lfsr_d;
      btn_prev_q <= btn_prev_d;
      color_q    <= color_d;
    end
  end

  assign color = color_q;

endmodule : life_game
`default_nettype wire

// File: tb/tb_life_game.sv
`default_nettype none
// ============================================================================
//  Module   : tb_life_game
//  Purpose  : Directed self-checking bench for life_game (STEP_PERIOD = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_life_game;
  import life_game_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] button;
  logic [9:0] x_position;
  logic [8:0] y_position;
  logic       inside_video;
  logic [7:0] color;

  int n_checks = 0;
  int n_fail   = 0;
  int n_commit = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  life_game #(
    .STEP_PERIOD (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .button       (button),
    .x_position   (x_position),
    .y_position   (y_position),
    .inside_video (inside_video),
    .color        (color)
  );

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && dut.state_q == COMMIT) n_commit <= n_commit + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ci(input int col, input int row);
    return row * GRID_W + col;
  endfunction

  // Called at a negedge; returns the colour registered for (x,y).
  task automatic sample_pixel(input int x, input int y, input logic iv, output logic [7:0] c);
    x_position   = 10'(x);
    y_position   = 9'(y);
    inside_video = iv;
    @(negedge clock);
    c = color;
  endtask

  task automatic scan_grid(output logic [CELL_COUNT-1:0] g);
    logic [7:0] c;
    g = '0;
    for (int r = 0; r < GRID_H; r++) begin
      for (int k = 0; k < GRID_W; k++) begin
        sample_pixel(k * 16 + 8, r * 16 + 8, 1'b1, c);
        g[ci(k, r)] = (c == 8'h1C);
      end
    end
  endtask

  task automatic check_grid(input string tag, input logic [CELL_COUNT-1:0] exp);
    logic [CELL_COUNT-1:0] g;
    int diff;
    scan_grid(g);
    diff = 0;
    for (int i = 0; i < CELL_COUNT; i++) if (g[i] !== exp[i]) diff++;
    check({tag, "_diff"}, 32'(diff), 32'd0);
    check({tag, "_live"}, 32'($countones(g)), 32'($countones(exp)));
  endtask

  task automatic press(input int b, input int cycles);
    button[b] = 1'b1;
    repeat (cycles) @(negedge clock);
    button[b] = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_state(input state_e s, input int budget, input string tag);
    int k;
    k = 0;
    while (dut.state_q != s && k < budget) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_reached"}, 32'(dut.state_q == s), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]            c;
    logic [CELL_COUNT-1:0] p;
    logic [CELL_COUNT-1:0] g;
    int                    c0;
    int                    t0;
    int                    k;

    button       = 4'd0;
    x_position   = '0;
    y_position   = '0;
    inside_video = 1'b0;
    repeat (3) @(negedge clock);

    // ---------------- reset state ----------------
    check("rst_color",   32'(color),          32'h00);
    check("rst_running", 32'(dut.running_q),  32'd1);
    check("rst_state",   32'(dut.state_q),    32'(IDLE));
    check("rst_timer",   32'(dut.timer_q),    32'd0);
    check("rst_lfsr",    32'(dut.lfsr_q),     32'hACE1);

    reset = 1'b0;
    t0 = cyc;
    @(negedge clock);
    check("lfsr_step1", 32'(dut.lfsr_q), 32'h5670);

    // ---------------- display of the reset glider ----------------
    sample_pixel(24, 8, 1'b1, c);   check("px_live_1_0", 32'(c), 32'h1C);
    sample_pixel(8, 8, 1'b1, c);    check("px_dead_0_0", 32'(c), 32'h00);
    sample_pixel(24, 8, 1'b0, c);   check("blank_video", 32'(c), 32'h00);
    sample_pixel(680, 8, 1'b1, c);  check("blank_x680",  32'(c), 32'h00);
    sample_pixel(700, 8, 1'b1, c);  check("blank_x700",  32'(c), 32'h00);
    sample_pixel(24, 500, 1'b1, c); check("blank_y500",  32'(c), 32'h00);
    sample_pixel(40, 24, 1'b1, c);  check("px_live_2_1", 32'(c), 32'h1C);

    // ---------------- first timed generation ----------------
    wait_state(COMMIT, 3000, "gen1_commit");
    check("gen1_latency", 32'(cyc - t0), 32'd1208);
    press(0, 1);  // pause right as the commit lands
    check("pause_running", 32'(dut.running_q), 32'd0);
    p = '0;
    p[ci(0, 1)] = 1'b1; p[ci(2, 1)] = 1'b1; p[ci(1, 2)] = 1'b1;
    p[ci(2, 2)] = 1'b1; p[ci(1, 3)] = 1'b1;
    check_grid("gen1", p);

    c0 = n_commit;
    repeat (5000) @(negedge clock);
    check("pause_no_commit", 32'(n_commit - c0), 32'd0);

    // ---------------- single step ----------------
    c0 = n_commit;
    press(1, 1);
    repeat (1300) @(negedge clock);
    check("step_pulse_one", 32'(n_commit - c0), 32'd1);
    p = '0;
    p[ci(2, 1)] = 1'b1; p[ci(0, 2)] = 1'b1; p[ci(2, 2)] = 1'b1;
    p[ci(1, 3)] = 1'b1; p[ci(2, 3)] = 1'b1;
    check_grid("gen2", p);

    c0 = n_commit;
    press(1, 3000);
    repeat (20) @(negedge clock);
    check("step_held_one", 32'(n_commit - c0), 32'd1);

    // ---------------- clear while paused ----------------
    press(3, 1);
    check("clr_state",   32'(dut.state_q),   32'(IDLE));
    check("clr_running", 32'(dut.running_q), 32'd0);
    check_grid("clr", '0);

    // ---------------- blinker via backdoor ----------------
    p = '0;
    p[ci(5, 10)] = 1'b1; p[ci(6, 10)] = 1'b1; p[ci(7, 10)] = 1'b1;
    dut.cur_q = p;
    @(negedge clock);
    press(1, 1);
    repeat (1300) @(negedge clock);
    g = '0;
    g[ci(6, 9)] = 1'b1; g[ci(6, 10)] = 1'b1; g[ci(6, 11)] = 1'b1;
    check_grid("blink_v", g);
    press(1, 1);
    repeat (1300) @(negedge clock);
    check_grid("blink_h", p);

    // ---------------- blinker straddling both wrap edges ----------------
    p = '0;
    p[ci(39, 0)] = 1'b1; p[ci(0, 0)] = 1'b1; p[ci(1, 0)] = 1'b1;
    dut.cur_q = p;
    @(negedge clock);
    press(1, 1);
    repeat (1300) @(negedge clock);
    g = '0;
    g[ci(0, 29)] = 1'b1; g[ci(0, 0)] = 1'b1; g[ci(0, 1)] = 1'b1;
    check_grid("wrap", g);

    // ---------------- randomize ----------------
    press(2, 1);
    repeat (1300) @(negedge clock);
    scan_grid(g);
    check("rand_density",
          32'(($countones(g) > 300) && ($countones(g) < 900)), 32'd1);

    // ---------------- clear in the middle of a running sweep ----------------
    press(0, 1);
    check("resume_running", 32'(dut.running_q), 32'd1);
    k = 0;
    while (!(dut.state_q == SWEEP && dut.idx_q == 11'd600) && k < 3000) begin
      @(negedge clock);
      k++;
    end
    check("midsweep_reached", 32'(dut.state_q == SWEEP && dut.idx_q == 11'd600), 32'd1);
    button[3] = 1'b1;
    @(negedge clock);
    button[3] = 1'b0;
    check("midclr_state",   32'(dut.state_q),   32'(IDLE));
    check("midclr_running", 32'(dut.running_q), 32'd1);
    check("midclr_timer",   32'(dut.timer_q),   32'd0);
    check_grid("midclr", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_life_game
`default_nettype wire
